// File: rtl/riscv_system_switch_ctrl_if.sv
// Avalon-MM slave bus bundle for the slide-switch controller.
// Readdata is returned one cycle after the address is presented.
interface riscv_system_switch_ctrl_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata
   );
endinterface

// File: rtl/riscv_system_switch_ctrl.sv
// Slide-switch controller: resynchronise, debounce, capture edges, maskable irq.
// Register map: 0 DATA (RO), 1 IRQ_MASK (RW), 2 EDGE_CAP (W1C), 3 CTRL (RW).
module riscv_system_switch_ctrl #(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   riscv_system_switch_ctrl_if.slave bus,
   input  logic [WIDTH-1:0]     in_port,
   output logic                 irq
);

   logic [WIDTH-1:0] sync1_reg;
   logic [WIDTH-1:0] sync_reg;
   logic [WIDTH-1:0] stable_w;
   logic [WIDTH-1:0] stable_d_reg;
   logic [WIDTH-1:0] irq_mask_reg;
   logic [WIDTH-1:0] edge_cap_reg;
   logic [WIDTH-1:0] edge_cap_next;
   logic [WIDTH-1:0] edge_sel;
   logic [WIDTH-1:0] w1c_clear;
   logic             deb_en_reg;
   logic             both_edges_reg;
   logic [31:0]      readdata_reg;
   logic [31:0]      readdata_next;
   logic             wr_en;
   logic             deb_toggle;
   logic             unused_wdata;

   assign wr_en        = bus.chipselect && !bus.write_n;
   assign deb_toggle   = wr_en && (bus.address == 2'd3) && (bus.writedata[0] != deb_en_reg);
   assign unused_wdata = ^bus.writedata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_reg <= '0;
         sync_reg  <= '0;
      end else begin
         sync1_reg <= in_port;
         sync_reg  <= sync1_reg;
      end
   end

   // Each bit owns its counter; a level is accepted only after it has differed
   // from the accepted value for DEBOUNCE_CYCLES consecutive cycles.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [CNT_W-1:0] cnt_reg;
      logic             stable_bit_reg;

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            cnt_reg        <= '0;
            stable_bit_reg <= 1'b0;
         end else begin
            if (!deb_en_reg) begin
               stable_bit_reg <= sync_reg[gi];
               cnt_reg        <= '0;
            end else if (sync_reg[gi] != stable_bit_reg) begin
               if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                  stable_bit_reg <= sync_reg[gi];
                  cnt_reg        <= '0;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end else begin
               cnt_reg <= '0;
            end
            if (deb_toggle) begin
               cnt_reg <= '0;
            end
         end
      end

      assign stable_w[gi] = stable_bit_reg;
   end

   always_comb begin
      edge_sel = stable_w & ~stable_d_reg;
      if (both_edges_reg) begin
         edge_sel = edge_sel | (~stable_w & stable_d_reg);
      end
      w1c_clear = '0;
      if (wr_en && (bus.address == 2'd2)) begin
         w1c_clear = bus.writedata[WIDTH-1:0];
      end
      // A new edge on the clearing cycle must not be lost.
      edge_cap_next = (edge_cap_reg & ~w1c_clear) | edge_sel;
   end

   always_comb begin
      readdata_next = '0;
      case (bus.address)
         2'd0:    readdata_next = 32'(stable_w);
         2'd1:    readdata_next = 32'(irq_mask_reg);
         2'd2:    readdata_next = 32'(edge_cap_reg);
         default: readdata_next = {30'd0, both_edges_reg, deb_en_reg};
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stable_d_reg   <= '0;
         irq_mask_reg   <= '0;
         edge_cap_reg   <= '0;
         deb_en_reg     <= 1'b1;
         both_edges_reg <= 1'b0;
         readdata_reg   <= '0;
      end else begin
         stable_d_reg <= stable_w;
         edge_cap_reg <= edge_cap_next;
         readdata_reg <= readdata_next;
         if (wr_en && (bus.address == 2'd1)) begin
            irq_mask_reg <= bus.writedata[WIDTH-1:0];
         end
         if (wr_en && (bus.address == 2'd3)) begin
            deb_en_reg     <= bus.writedata[0];
            both_edges_reg <= bus.writedata[1];
         end
      end
   end

   assign bus.readdata = readdata_reg;
   assign irq          = |(edge_cap_reg & irq_mask_reg);

endmodule
